scan_config_loader: RTL and testbench

//  Host-side writer for the fabric configuration scan chain. Accepts config words over a

---
 rtl/scan_config_loader.sv | 182 ++++++++++++++++++
 tb/tb_scan_config_loader.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_config_loader.sv
// Serialises host config words onto the fabric scan chain and gates its scan enable.
// Define SCAN_VERIFY_EN to add a CRC-16 recirculating readback check after each load.
module scan_config_loader #(
    parameter int unsigned CHAIN_LEN  = 32,
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_scan_in,
    output logic                  chain_scan_en,
    input  logic                  chain_scan_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int unsigned SW = $clog2(WORD_WIDTH + 1);
    localparam int unsigned AW = CNT_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] LastBit   = CNT_WIDTH'(CHAIN_LEN - 1);
    localparam logic [AW-1:0]        AccLimit  = AW'(CHAIN_LEN);
    localparam logic [AW-1:0]        AccStep   = AW'(WORD_WIDTH);
    localparam logic [SW-1:0]        FullShift = SW'(WORD_WIDTH);

`ifdef SCAN_VERIFY_EN
    typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;
`else
    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
`endif

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_valid_q, buf_valid_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [SW-1:0]         shift_left_q, shift_left_d;
    logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic [AW-1:0]         acc_q, acc_d;
    logic                  shifting, accept, shifter_drains;

`ifdef SCAN_VERIFY_EN
    logic [15:0] crc_ref_q, crc_ref_d;
    logic [15:0] crc_chk_q, crc_chk_d;
    logic [15:0] crc_chk_next;
    logic        error_q, error_d;

    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic din);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? 16'h1021 : 16'h0000);
    endfunction

    assign crc_chk_next = crc_step(crc_chk_q, chain_scan_out);
    assign error        = error_q;
`else
    logic unused_scan_out;
    assign unused_scan_out = chain_scan_out;
    assign error           = 1'b0;
`endif

    assign busy       = (state_q != StIdle);
    assign done       = (state_q == StDone);
    // acc_q counts bits accepted, so the partial final word still closes the window
    assign word_ready = (state_q == StLoad) && !buf_valid_q && (acc_q < AccLimit);
    assign accept     = word_ready && word_valid;
    assign shifting   = (state_q == StLoad) && (shift_left_q != '0);
    // Shifter is free for a new word at the next edge
    assign shifter_drains = (shift_left_q == '0) || ((shift_left_q == SW'(1)) && shifting);

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        buf_valid_d   = buf_valid_q;
        shift_d       = shift_q;
        shift_left_d  = shift_left_q;
        bit_cnt_d     = bit_cnt_q;
        acc_d         = acc_q;
        chain_scan_en = shifting;
        chain_scan_in = shifting & shift_q[0];
`ifdef SCAN_VERIFY_EN
        crc_ref_d     = crc_ref_q;
        crc_chk_d     = crc_chk_q;
        error_d       = error_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StLoad;
                    bit_cnt_d    = '0;
                    acc_d        = '0;
                    buf_valid_d  = 1'b0;
                    shift_left_d = '0;
`ifdef SCAN_VERIFY_EN
                    error_d      = 1'b0;
                    crc_ref_d    = 16'hFFFF;
`endif
                end
            end
            StLoad: begin
                if (shifting) begin
                    shift_d      = shift_q >> 1;
                    shift_left_d = shift_left_q - SW'(1);
                    bit_cnt_d    = bit_cnt_q + CNT_WIDTH'(1);
`ifdef SCAN_VERIFY_EN
                    crc_ref_d    = crc_step(crc_ref_q, shift_q[0]);
`endif
                end
                if (accept) begin
                    acc_d = acc_q + AccStep;
                end
                // A word accepted while the shifter drains bypasses the buffer
                if (shifter_drains) begin
                    if (buf_valid_q) begin
                        shift_d      = buf_q;
                        shift_left_d = FullShift;
                        buf_valid_d  = 1'b0;
                    end else if (accept) begin
                        shift_d      = word_in;
                        shift_left_d = FullShift;
                    end
                end else if (accept) begin
                    buf_d       = word_in;
                    buf_valid_d = 1'b1;
                end
                if (shifting && (bit_cnt_q == LastBit)) begin
`ifdef SCAN_VERIFY_EN
                    state_d   = StVerify;
                    bit_cnt_d = '0;
                    crc_chk_d = 16'hFFFF;
`else
                    state_d   = StDone;
`endif
                end
            end
`ifdef SCAN_VERIFY_EN
            StVerify: begin
                chain_scan_en = 1'b1;
                chain_scan_in = chain_scan_out;
                bit_cnt_d     = bit_cnt_q + CNT_WIDTH'(1);
                crc_chk_d     = crc_chk_next;
                if (bit_cnt_q == LastBit) begin
                    error_d = (crc_chk_next != crc_ref_q);
                    state_d = StDone;
                end
            end
`endif
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            shift_q      <= '0;
            shift_left_q <= '0;
            bit_cnt_q    <= '0;
            acc_q        <= '0;
`ifdef SCAN_VERIFY_EN
            crc_ref_q    <= 16'hFFFF;
            crc_chk_q    <= 16'hFFFF;
            error_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            shift_q      <= shift_d;
            shift_left_q <= shift_left_d;
            bit_cnt_q    <= bit_cnt_d;
            acc_q        <= acc_d;
`ifdef SCAN_VERIFY_EN
            crc_ref_q    <= crc_ref_d;
            crc_chk_q    <= crc_chk_d;
            error_q      <= error_d;
`endif
        end
    end

endmodule

// File: tb/tb_scan_config_loader.sv
// Directed bench for scan_config_loader: a 32-bit and a 12-bit instance, each driving a
// behavioural scan-chain model.
module tb_scan_config_loader;
    localparam int unsigned LEN_A = 32;
    localparam int unsigned LEN_B = 12;
`ifdef SCAN_VERIFY_EN
    localparam int unsigned EN_MUL = 2;
`else
    localparam int unsigned EN_MUL = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0, word_valid_a = 1'b0;
    logic [7:0] word_in_a = 8'h00;
    logic       word_ready_a, scan_in_a, scan_en_a, scan_out_a, busy_a, done_a, error_a;
    logic       start_b = 1'b0, word_valid_b = 1'b0;
    logic [7:0] word_in_b = 8'h00;
    logic       word_ready_b, scan_in_b, scan_en_b, scan_out_b, busy_b, done_b, error_b;

    scan_config_loader #(.CHAIN_LEN(LEN_A), .WORD_WIDTH(8), .CNT_WIDTH(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .word_in(word_in_a),
        .word_valid(word_valid_a), .word_ready(word_ready_a), .chain_scan_in(scan_in_a),
        .chain_scan_en(scan_en_a), .chain_scan_out(scan_out_a), .busy(busy_a),
        .done(done_a), .error(error_a)
    );

    scan_config_loader #(.CHAIN_LEN(LEN_B), .WORD_WIDTH(8), .CNT_WIDTH(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .word_in(word_in_b),
        .word_valid(word_valid_b), .word_ready(word_ready_b), .chain_scan_in(scan_in_b),
        .chain_scan_en(scan_en_b), .chain_scan_out(scan_out_b), .busy(busy_b),
        .done(done_b), .error(error_b)
    );

    // Chain model: first bit shifted ends at bit 0, the position farthest from scan_in
    logic [LEN_A-1:0] chain_a = '0;
    logic [LEN_B-1:0] chain_b = '0;
    logic             flip_a  = 1'b0;
    assign scan_out_a = chain_a[0] ^ flip_a;
    assign scan_out_b = chain_b[0];

    always @(posedge clk) begin
        if (scan_en_a) chain_a <= {scan_in_a, chain_a[LEN_A-1:1]};
        if (scan_en_b) chain_b <= {scan_in_b, chain_b[LEN_B-1:1]};
    end

    int en_a = 0, gap_a = 0, dcnt_a = 0, badin_a = 0;
    int en_b = 0, gap_b = 0, dcnt_b = 0, badin_b = 0, acc_b = 0;
    logic seen_a = 1'b0, seen_b = 1'b0;

    always @(negedge clk) begin
        if (scan_en_a) en_a <= en_a + 1;
        if (!busy_a) seen_a <= 1'b0; else if (scan_en_a) seen_a <= 1'b1;
        if (busy_a && !scan_en_a && !done_a && seen_a) gap_a <= gap_a + 1;
        if (done_a) dcnt_a <= dcnt_a + 1;
        if (!scan_en_a && scan_in_a) badin_a <= badin_a + 1;
        if (scan_en_b) en_b <= en_b + 1;
        if (!busy_b) seen_b <= 1'b0; else if (scan_en_b) seen_b <= 1'b1;
        if (busy_b && !scan_en_b && !done_b && seen_b) gap_b <= gap_b + 1;
        if (done_b) dcnt_b <= dcnt_b + 1;
        if (!scan_en_b && scan_in_b) badin_b <= badin_b + 1;
    end

    always @(posedge clk) begin
        if (word_valid_b && word_ready_b) acc_b <= acc_b + 1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_a(input logic [7:0] w);
        int guard = 0;
        word_in_a    = w;
        word_valid_a = 1'b1;
        while (!word_ready_a && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("send_a_ready", 32'(word_ready_a), 32'd1);
        @(negedge clk);
        word_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] w);
        int guard = 0;
        word_in_b    = w;
        word_valid_b = 1'b1;
        while (!word_ready_b && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_eq("send_b_ready", 32'(word_ready_b), 32'd1);
        @(negedge clk);
        word_valid_b = 1'b0;
    endtask

    task automatic wait_done_a();
        int guard = 0;
        while (!done_a && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check_eq("done_a_seen", 32'(done_a), 32'd1);
    endtask

    task automatic wait_done_b();
        int guard = 0;
        while (!done_b && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check_eq("done_b_seen", 32'(done_b), 32'd1);
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic load4_a();
        send_a(8'hA5);
        send_a(8'h3C);
        send_a(8'hFF);
        send_a(8'h00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, g0, d0, a0, guard;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy_a", 32'(busy_a), 32'd0);
        check_eq("rst_done_a", 32'(done_a), 32'd0);
        check_eq("rst_ready_a", 32'(word_ready_a), 32'd0);
        check_eq("rst_en_a", 32'(scan_en_a), 32'd0);
        check_eq("rst_error_a", 32'(error_a), 32'd0);
        check_eq("rst_busy_b", 32'(busy_b), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_ready_a", 32'(word_ready_a), 32'd0);

        // 1. Basic back-to-back load
        en0 = en_a; g0 = gap_a; d0 = dcnt_a;
        pulse_start_a();
        check_eq("t1_busy", 32'(busy_a), 32'd1);
        check_eq("t1_ready", 32'(word_ready_a), 32'd1);
        check_eq("t1_en_before_word", 32'(scan_en_a), 32'd0);
        word_in_a    = 8'hA5;
        word_valid_a = 1'b1;
        @(negedge clk);
        check_eq("t1_first_en", 32'(scan_en_a), 32'd1);
        check_eq("t1_first_bit", 32'(scan_in_a), 32'd1);
        send_a(8'h3C);
        send_a(8'hFF);
        send_a(8'h00);
        wait_done_a();
        repeat (3) @(negedge clk);
        check_eq("t1_en_cycles", en_a - en0, LEN_A * EN_MUL);
        check_eq("t1_gaps", gap_a - g0, 32'd0);
        check_eq("t1_done_pulses", dcnt_a - d0, 32'd1);
        check_eq("t1_chain", chain_a, 32'h00FF3CA5);
        check_eq("t1_busy_after", 32'(busy_a), 32'd0);
        check_eq("t1_error", 32'(error_a), 32'd0);

        // 2. Starvation: sender idles long enough after word 1 to starve the shifter 5 cycles
        en0 = en_a; g0 = gap_a; d0 = dcnt_a;
        pulse_start_a();
        send_a(8'hA5);
        send_a(8'h3C);
        repeat (19) @(negedge clk);
        send_a(8'hFF);
        send_a(8'h00);
        wait_done_a();
        repeat (3) @(negedge clk);
        check_eq("t2_en_cycles", en_a - en0, LEN_A * EN_MUL);
        check_eq("t2_stall_cycles", gap_a - g0, 32'd5);
        check_eq("t2_done_pulses", dcnt_a - d0, 32'd1);
        check_eq("t2_chain", chain_a, 32'h00FF3CA5);

        // 3. Partial last word on the 12-bit chain
        en0 = en_b; g0 = gap_b; d0 = dcnt_b; a0 = acc_b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        send_b(8'h5A);
        send_b(8'hF3);
        repeat (8) @(negedge clk);
        check_eq("t3_busy_mid", 32'(busy_b), 32'd1);
        check_eq("t3_ready_closed", 32'(word_ready_b), 32'd0);
        wait_done_b();
        repeat (3) @(negedge clk);
        check_eq("t3_en_cycles", en_b - en0, LEN_B * EN_MUL);
        check_eq("t3_words", acc_b - a0, 32'd2);
        check_eq("t3_chain", 32'(chain_b), 32'h35A);
        check_eq("t3_done_pulses", dcnt_b - d0, 32'd1);
        check_eq("t3_gaps", gap_b - g0, 32'd0);

        // 4. Reset mid-load, then full reload
        en0 = en_a;
        pulse_start_a();
        send_a(8'h12);
        send_a(8'h34);
        guard = 0;
        while ((en_a - en0) < 10 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_eq("t4_busy_pre", 32'(busy_a), 32'd1);
        check_eq("t4_en_pre", 32'(scan_en_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t4_rst_en", 32'(scan_en_a), 32'd0);
        check_eq("t4_rst_busy", 32'(busy_a), 32'd0);
        check_eq("t4_rst_ready", 32'(word_ready_a), 32'd0);
        check_eq("t4_rst_done", 32'(done_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en0 = en_a; d0 = dcnt_a;
        pulse_start_a();
        load4_a();
        wait_done_a();
        repeat (3) @(negedge clk);
        check_eq("t4_reload_en", en_a - en0, LEN_A * EN_MUL);
        check_eq("t4_reload_chain", chain_a, 32'h00FF3CA5);
        check_eq("t4_reload_done", dcnt_a - d0, 32'd1);

        // 5. start held through LOAD and pulsed in the DONE cycle is ignored
        en0 = en_a; d0 = dcnt_a;
        start_a = 1'b1;
        @(negedge clk);
        send_a(8'hC3);
        send_a(8'h96);
        send_a(8'h0F);
        send_a(8'hE1);
        start_a = 1'b0;
        wait_done_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("t5_busy_after", 32'(busy_a), 32'd0);
        check_eq("t5_done_pulses", dcnt_a - d0, 32'd1);
        check_eq("t5_en_cycles", en_a - en0, LEN_A * EN_MUL);
        check_eq("t5_chain", chain_a, 32'hE10F96C3);

`ifdef SCAN_VERIFY_EN
        // 6. Readback verify: intact, then one corrupted recirculated bit
        pulse_start_a();
        load4_a();
        wait_done_a();
        repeat (3) @(negedge clk);
        check_eq("t6_ok_error", 32'(error_a), 32'd0);
        check_eq("t6_ok_chain", chain_a, 32'h00FF3CA5);
        en0 = en_a;
        pulse_start_a();
        load4_a();
        guard = 0;
        while ((en_a - en0) < 40 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        flip_a = 1'b1;
        @(negedge clk);
        flip_a = 1'b0;
        wait_done_a();
        repeat (5) @(negedge clk);
        check_eq("t6_bad_error", 32'(error_a), 32'd1);
        pulse_start_a();
        check_eq("t6_error_cleared", 32'(error_a), 32'd0);
        load4_a();
        wait_done_a();
        repeat (3) @(negedge clk);
        check_eq("t6_reload_error", 32'(error_a), 32'd0);
`endif

        check_eq("idle_in_a", badin_a, 32'd0);
        check_eq("idle_in_b", badin_b, 32'd0);
        check_eq("error_b", 32'(error_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
